// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types, defaults and helpers for the UART RX front end.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int DEF_PRESCALE   = 8;
    localparam int DEF_DATA_WIDTH = 8;

    // Three mid-bit sample edges, centred on prescale/2.
    function automatic logic [2:0][15:0] sample_points(input int prescale);
        logic [2:0][15:0] pts;
        pts[0] = 16'(prescale / 2 - 1);
        pts[1] = 16'(prescale / 2);
        pts[2] = 16'(prescale / 2 + 1);
        return pts;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Brief    : Bit-period edge counter, mid-bit sampling and 2-of-3 vote.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic rx,
    output logic sampled_bit,
    output logic bit_tick
);

    localparam int               CW   = $clog2(PRESCALE);
    localparam logic [2:0][15:0] PTS  = sample_points(PRESCALE);
    localparam logic [CW-1:0]    S0   = PTS[0][CW-1:0];
    localparam logic [CW-1:0]    S1   = PTS[1][CW-1:0];
    localparam logic [CW-1:0]    S2   = PTS[2][CW-1:0];
    localparam logic [CW-1:0]    LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] edge_cnt;
    logic [1:0]    samp;

    assign bit_tick = (edge_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (!run || bit_tick) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    // The third sample feeds the vote directly so the result is visible on
    // the very next edge and held until the following bit's vote.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp        <= 2'b11;
            sampled_bit <= 1'b1;
        end else if (run) begin
            if (edge_cnt == S0) samp[0] <= rx;
            if (edge_cnt == S1) samp[1] <= rx;
            if (edge_cnt == S2) sampled_bit <= majority3(samp[0], samp[1], rx);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_frontend.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frontend
// Brief    : UART RX framing FSM, LSB-first deserializer and frame strobes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int PRESCALE   = DEF_PRESCALE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_rf,
    input  logic                  rst_rf,
    input  logic                  rx_in_rf,
    input  logic                  par_en_rf,
    input  logic                  par_error_rf,
    output logic                  sampled_bit_rf,
    output logic [DATA_WIDTH-1:0] p_data_rf,
    output logic                  par_check_en_rf,
    output logic                  data_valid_rf,
    output logic                  stp_err_rf,
    output logic                  busy_rf
);

    localparam int            BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    rx_state_t     state;
    rx_state_t     next_state;
    logic          bit_tick;
    logic          start_seen;
    logic          par_en_q;
    logic [BW-1:0] bit_cnt;

    assign start_seen = (state == IDLE) && !rx_in_rf;

    uart_rx_sampler #(
        .PRESCALE (PRESCALE)
    ) u_sampler (
        .clk         (clk_rf),
        .rst         (rst_rf),
        .run         (start_seen || (state != IDLE)),
        .rx          (rx_in_rf),
        .sampled_bit (sampled_bit_rf),
        .bit_tick    (bit_tick)
    );

    always_ff @(posedge clk_rf or posedge rst_rf) begin
        if (rst_rf) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (!rx_in_rf) next_state = START;
            START:  if (bit_tick) next_state = sampled_bit_rf ? IDLE : DATA;
            DATA:   if (bit_tick && (bit_cnt == LAST_BIT))
                        next_state = par_en_q ? PARITY : STOP;
            PARITY: if (bit_tick) next_state = STOP;
            STOP:   if (bit_tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_rf         = (state != IDLE);
        par_check_en_rf = (state == PARITY) && bit_tick;
    end

    always_ff @(posedge clk_rf or posedge rst_rf) begin
        if (rst_rf) begin
            par_en_q  <= 1'b0;
            bit_cnt   <= '0;
            p_data_rf <= '0;
        end else begin
            if (start_seen) par_en_q <= par_en_rf;
            if ((state == DATA) && bit_tick) begin
                p_data_rf <= {sampled_bit_rf, p_data_rf[DATA_WIDTH-1:1]};
                bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    // A parity error from the checker suppresses data_valid but is not a stop error.
    always_ff @(posedge clk_rf or posedge rst_rf) begin
        if (rst_rf) begin
            data_valid_rf <= 1'b0;
            stp_err_rf    <= 1'b0;
        end else begin
            data_valid_rf <= (state == STOP) && bit_tick && sampled_bit_rf &&
                             (!par_en_q || !par_error_rf);
            stp_err_rf    <= (state == STOP) && bit_tick && !sampled_bit_rf;
        end
    end

endmodule
`default_nettype wire
